// File: rtl/idct_pkg.sv
// Shared constants, basis table and FSM state type for the 8-point IDCT engine.
package idct_pkg;

    localparam int COEF_W    = 16;
    localparam int COEF_FRAC = 14;
    localparam int NUM_PTS   = 8;

    // Q1.14 basis: IDCT_BASIS[k][n] = round(2^14 * a(k) * cos((2n+1)k*pi/16))
    localparam logic signed [COEF_W-1:0] IDCT_BASIS [NUM_PTS][NUM_PTS] = '{
        '{ 16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793},
        '{ 16'sd8035,  16'sd6811,  16'sd4551,  16'sd1598, -16'sd1598, -16'sd4551, -16'sd6811, -16'sd8035},
        '{ 16'sd7568,  16'sd3135, -16'sd3135, -16'sd7568, -16'sd7568, -16'sd3135,  16'sd3135,  16'sd7568},
        '{ 16'sd6811, -16'sd1598, -16'sd8035, -16'sd4551,  16'sd4551,  16'sd8035,  16'sd1598, -16'sd6811},
        '{ 16'sd5793, -16'sd5793, -16'sd5793,  16'sd5793,  16'sd5793, -16'sd5793, -16'sd5793,  16'sd5793},
        '{ 16'sd4551, -16'sd8035,  16'sd1598,  16'sd6811, -16'sd6811, -16'sd1598,  16'sd8035, -16'sd4551},
        '{ 16'sd3135, -16'sd7568,  16'sd7568, -16'sd3135, -16'sd3135,  16'sd7568, -16'sd7568,  16'sd3135},
        '{ 16'sd1598, -16'sd4551,  16'sd6811, -16'sd8035,  16'sd8035, -16'sd6811,  16'sd4551, -16'sd1598}
    };

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

endpackage

// File: rtl/idct_dot8.sv
// Combinational 8-term dot product of the latched coefficients with one basis
// column, followed by round-half-up and saturation to the sample width.
module idct_dot8
    import idct_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH*NUM_PTS-1:0] coef,
    input  logic [COEF_W*NUM_PTS-1:0]     basis_col,
    output logic [DATA_WIDTH-1:0]         result
);

    localparam int PROD_W = DATA_WIDTH + COEF_W;
    localparam int SUM_W  = DATA_WIDTH + COEF_W + 3;

    localparam logic signed [SUM_W-1:0] HALF_LSB = SUM_W'(1) <<< (COEF_FRAC - 1);
    localparam logic signed [SUM_W-1:0] SAT_MAX  = (SUM_W'(1) <<< (DATA_WIDTH - 1)) - SUM_W'(1);
    localparam logic signed [SUM_W-1:0] SAT_MIN  = -(SUM_W'(1) <<< (DATA_WIDTH - 1));

    logic signed [PROD_W-1:0] prod [NUM_PTS];
    logic signed [SUM_W-1:0]  acc;
    logic signed [SUM_W-1:0]  rounded;

    // Full-precision signed products; operands are sign-extended to product width first
    always_comb begin
        for (int k = 0; k < NUM_PTS; k++) begin
            prod[k] = PROD_W'($signed(coef[k*DATA_WIDTH +: DATA_WIDTH]))
                    * PROD_W'($signed(basis_col[k*COEF_W +: COEF_W]));
        end
    end

    // Accumulate with 3 guard bits, round half up, then clamp into the sample range
    always_comb begin
        acc = '0;
        for (int k = 0; k < NUM_PTS; k++) begin
            acc = acc + SUM_W'(prod[k]);
        end
        rounded = (acc + HALF_LSB) >>> COEF_FRAC;
        if (rounded > SAT_MAX) begin
            result = SAT_MAX[DATA_WIDTH-1:0];
        end else if (rounded < SAT_MIN) begin
            result = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            result = rounded[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/idct_8pt_seq.sv
// Sequential inverse 8-point DCT: accepts a block of 8 coefficients, then
// streams 8 reconstructed samples through a registered valid/ready output.
module idct_8pt_seq
    import idct_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH*DATA_DEPTH-1:0] data_in,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [2:0]                       out_index,
    output logic                             out_last
);

    state_t                           state;
    logic [2:0]                       idx;
    logic [DATA_WIDTH*DATA_DEPTH-1:0] coef_q;
    logic [COEF_W*NUM_PTS-1:0]        basis_col;
    logic [DATA_WIDTH-1:0]            dot_result;
    logic                             out_load;

    assign in_ready = (state == IDLE);
    assign out_load = !out_valid || out_ready;

    // Select basis column idx so the dot product yields sample x[idx]
    always_comb begin
        basis_col = '0;
        for (int k = 0; k < NUM_PTS; k++) begin
            basis_col[k*COEF_W +: COEF_W] = IDCT_BASIS[k][idx];
        end
    end

    idct_dot8 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_dot8 (
        .coef      (coef_q),
        .basis_col (basis_col),
        .result    (dot_result)
    );

    // Block FSM plus coefficient latch and output register; a new block may be
    // taken in IDLE even while the final sample still waits downstream
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= 3'd0;
            coef_q    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= 3'd0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                    if (in_valid) begin
                        coef_q <= data_in;
                        idx    <= 3'd0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (out_load) begin
                        out_data  <= dot_result;
                        out_index <= idx;
                        out_last  <= (idx == 3'd7);
                        out_valid <= 1'b1;
                        idx       <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_idct_8pt_seq.sv
// Scoreboard bench for idct_8pt_seq: expected samples come from an independent
// behavioural IDCT model and are matched against every output transfer.
module tb_idct_8pt_seq;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] data_in;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic [2:0]   out_index;
    logic         out_last;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  index;
        logic        last;
        logic        rt;
        int          orig;
    } exp_t;

    exp_t sb[$];
    int   xfer_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   xfer_count = 0;
    int   cycle = 0;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    idct_8pt_seq #(
        .DATA_WIDTH (32),
        .DATA_DEPTH (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle counter used for latency and throughput measurement
    always @(posedge clk) cycle <= cycle + 1;

    // Basis derived from 8192*cos(m*pi/16) with quadrant folding
    function automatic longint basis(input int k, input int n);
        int ct[9] = '{8192, 8035, 7568, 6811, 5793, 4551, 3135, 1598, 0};
        int m;
        if (k == 0) return 5793;
        m = ((2 * n + 1) * k) % 32;
        if (m <= 8)  return ct[m];
        if (m <= 16) return -ct[16 - m];
        if (m <= 24) return -ct[m - 16];
        return ct[32 - m];
    endfunction

    function automatic logic [31:0] idct_model(input logic [255:0] blk, input int n);
        longint acc = 0;
        for (int k = 0; k < 8; k++) begin
            acc += longint'($signed(blk[k*32 +: 32])) * basis(k, n);
        end
        acc = (acc + 8192) >>> 14;
        if (acc > SMAX) return 32'h7FFFFFFF;
        if (acc < SMIN) return 32'h80000000;
        return acc[31:0];
    endfunction

    // Scoreboard: every transfer pops one expectation and compares it
    always @(negedge clk) begin
        exp_t e;
        int   diff;
        if (!reset && out_valid && out_ready) begin
            xfer_count++;
            xfer_cyc.push_back(cycle);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_output got data %0h index %0d expected no transfer",
                         out_data, out_index);
            end else begin
                e = sb.pop_front();
                if (out_data !== e.data || out_index !== e.index || out_last !== e.last) begin
                    errors++;
                    $display("[TB] FAIL sample got data %0h index %0d last %0b expected data %0h index %0d last %0b",
                             out_data, out_index, out_last, e.data, e.index, e.last);
                end
                if (e.rt) begin
                    checks++;
                    diff = $signed(out_data) - e.orig;
                    if (diff > 1 || diff < -1) begin
                        errors++;
                        $display("[TB] FAIL round_trip got %0d expected %0d +/-1",
                                 $signed(out_data), e.orig);
                    end
                end
            end
        end
    end

    task automatic send_block(input logic [255:0] blk, input logic rt, input int orig[8]);
        int n = 0;
        for (int i = 0; i < 8; i++) begin
            sb.push_back('{data: idct_model(blk, i), index: 3'(i), last: (i == 7), rt: rt, orig: orig[i]});
        end
        data_in  = blk;
        in_valid = 1'b1;
        while (!in_ready && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout got in_ready %0b expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain got %0d pending expected 0", sb.size());
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_valid got %0b expected 0", out_valid);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b1;
        data_in  = 256'd1000;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_valid got %0b expected 0", out_valid);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset got ready %0b valid %0b expected ready 1 valid 0", in_ready, out_valid);
        end
        checks++;
        if (out_data !== 32'd0 || out_index !== 3'd0 || out_last !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got data %0h index %0d last %0b expected 0 0 0",
                     out_data, out_index, out_last);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL nothing_accepted got valid %0b ready %0b expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_dc_block();
        logic [255:0] blk = '0;
        int           z[8] = '{default: 0};
        blk[31:0] = 32'd1000;
        out_ready = 1'b1;
        send_block(blk, 1'b0, z);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL early_valid got %0b expected 0", out_valid);
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_index !== 3'(i)) begin
                errors++;
                $display("[TB] FAIL dc_stream got valid %0b index %0d expected valid 1 index %0d",
                         out_valid, out_index, i);
            end
        end
        wait_drain();
    endtask

    task automatic test_harmonic();
        logic [255:0] blk = '0;
        int           z[8] = '{default: 0};
        blk[63:32] = 32'd1000;
        out_ready = 1'b1;
        send_block(blk, 1'b0, z);
        wait_drain();
    endtask

    task automatic test_backpressure();
        logic [255:0] blk = '0;
        int           z[8] = '{default: 0};
        logic         pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic         stalled = 1'b0;
        logic [31:0]  held_data = '0;
        logic [2:0]   held_index = '0;
        int           start;
        int           i = 0;
        blk[31:0] = 32'd1000;
        start = xfer_count;
        send_block(blk, 1'b0, z);
        while (xfer_count - start < 8 && i < 100) begin
            out_ready = pat[i % 4];
            @(negedge clk);
            if (stalled) begin
                checks++;
                if (out_data !== held_data || out_index !== held_index) begin
                    errors++;
                    $display("[TB] FAIL stall_hold got data %0h index %0d expected data %0h index %0d",
                             out_data, out_index, held_data, held_index);
                end
            end
            stalled    = out_valid && !out_ready;
            held_data  = out_data;
            held_index = out_index;
            @(posedge clk);
            #1;
            i++;
        end
        out_ready = 1'b1;
        wait_drain();
        checks++;
        if (xfer_count - start != 8) begin
            errors++;
            $display("[TB] FAIL bp_transfers got %0d expected 8", xfer_count - start);
        end
    endtask

    task automatic test_saturation();
        logic [255:0] blk;
        int           z[8] = '{default: 0};
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) blk[k*32 +: 32] = 32'h7FFFFFFF;
        send_block(blk, 1'b0, z);
        for (int k = 0; k < 8; k++) blk[k*32 +: 32] = 32'h80000000;
        send_block(blk, 1'b0, z);
        wait_drain();
    endtask

    task automatic test_reset_mid_block();
        logic [255:0] blk = '0;
        int           z[8] = '{default: 0};
        int           start;
        int           n = 0;
        blk[31:0] = 32'd1000;
        out_ready = 1'b1;
        start = xfer_count;
        send_block(blk, 1'b0, z);
        while (xfer_count - start < 3 && n < 50) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (xfer_count - start < 3) begin
            errors++;
            $display("[TB] FAIL mid_transfers got %0d expected 3", xfer_count - start);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_index !== 3'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset got valid %0b index %0d expected 0 0", out_valid, out_index);
        end
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_ready got %0b expected 1", in_ready);
        end
        blk = '0;
        blk[63:32] = 32'd1000;
        send_block(blk, 1'b0, z);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        logic [255:0] a = '0;
        logic [255:0] b = '0;
        int           z[8] = '{default: 0};
        a[31:0]   = 32'd1000;
        b[95:64]  = -32'sd777;
        out_ready = 1'b1;
        xfer_cyc.delete();
        send_block(a, 1'b0, z);
        send_block(b, 1'b0, z);
        wait_drain();
        checks++;
        if (xfer_cyc.size() != 16) begin
            errors++;
            $display("[TB] FAIL b2b_count got %0d expected 16", xfer_cyc.size());
        end else begin
            checks++;
            if (xfer_cyc[15] - xfer_cyc[0] != 16) begin
                errors++;
                $display("[TB] FAIL b2b_span got %0d expected 16", xfer_cyc[15] - xfer_cyc[0]);
            end
        end
    endtask

    task automatic test_round_trip();
        int           x[8];
        logic [255:0] blk;
        longint       acc;
        int           err;
        logic         ok;
        out_ready = 1'b1;
        for (int b = 0; b < 5; b++) begin
            ok = 1'b0;
            for (int tries = 0; tries < 20 && !ok; tries++) begin
                for (int n = 0; n < 8; n++) x[n] = int'($urandom_range(4000)) - 2000;
                for (int k = 0; k < 8; k++) begin
                    acc = 0;
                    for (int n = 0; n < 8; n++) acc += longint'(x[n]) * basis(k, n);
                    acc = (acc + 8192) >>> 14;
                    blk[k*32 +: 32] = acc[31:0];
                end
                ok = 1'b1;
                for (int n = 0; n < 8; n++) begin
                    err = $signed(idct_model(blk, n)) - x[n];
                    if (err > 1 || err < -1) ok = 1'b0;
                end
            end
            send_block(blk, 1'b1, x);
        end
        wait_drain();
    endtask

    // Bound on total run time
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scenario sequence
    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        data_in   = '0;
        #1;
        test_reset();
        test_dc_block();
        test_harmonic();
        test_backpressure();
        test_saturation();
        test_reset_mid_block();
        test_back_to_back();
        test_round_trip();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
